traffic_countdown_timer: RTL and testbench
==========================================

Name: traffic_countdown_timer

Overview:
- Seconds countdown timer feeding the traffic light controller: produces the `rest_time` value the controller polls for zero.
- Reloads on the controller's one-cycle phase strobes (green/yellow/red/five/eight/save) and decrements once per second via an internal prescaler.
- Freezes on pause.
- Also supplies registered BCD digits for the seven-segment display and a one-cycle expiry pulse.

Parameters:
- CLK_DIV, 100_000_000, clk cycles per 1 s tick (bench uses 4).
- DIV_W, 27, prescaler width; must satisfy 2^DIV_W >= CLK_DIV.
- FIVE_VAL, 5, load value on `five_time`.
- EIGHT_VAL, 8, load value on `eight_time`.
- MAX_VAL, 99, upper clamp for any loaded value (2-digit display).

Ports:
- clk in 1: system clock, rising edge.
- rst in 1: synchronous, active-high reset.
- pause_r in 1: level; freezes prescaler and count.
- green_s in 1: pulse; load `green_time`.
- yellow_s in 1: pulse; load `yellow_time`.
- red_s in 1: pulse; load `red_time`.
- five_time in 1: pulse; load FIVE_VAL.
- eight_time in 1: pulse; load EIGHT_VAL.
- save_s in 1: pulse; load `p_rest_time` (resume after online override).
- init_s in 1: pulse; clear count to 0.
- green_time in 7: configured green duration, seconds.
- yellow_time in 7: configured yellow duration, seconds.
- red_time in 7: configured red duration, seconds.
- p_rest_time in 7: saved remaining time from the controller.
- rest_time out 7: current remaining seconds.
- tens out 4: BCD tens digit of `rest_time`.
- ones out 4: BCD ones digit of `rest_time`.
- expired out 1: one-cycle pulse on 1->0 decrement.

Behaviour:
- Reset (`rst` high at a clk edge) has priority over everything. It sets `rest_time`=0, prescaler=0, `tens`=0, `ones`=0, `expired`=0, and overrides any strobe in the same cycle.
- Load priority, when several strobes are high in one cycle: init_s > save_s > red_s > yellow_s > green_s > eight_time > five_time. Only the highest-priority strobe takes effect.
- Load arithmetic:
  - The value is clamped to [1, MAX_VAL], so loading 0 yields 1 and loading 120 yields 99.
  - Exception: `init_s` loads 0.
  - `save_s` with `p_rest_time`=0 loads 1. This is intentional; resume must never skip a phase.
- Load latency: strobe sampled at edge N -> `rest_time` holds the new value after edge N.
- Any load or `init_s` also clears the prescaler to 0, so a full second elapses before the first decrement.
- Loads are honoured even while `pause_r`=1. The count is then held until pause drops.
- Prescaler:
  - Counts 0..CLK_DIV-1 while `pause_r`=0 and no load is active.
  - `tick` is high for the cycle in which the prescaler equals CLK_DIV-1; the prescaler wraps to 0 on the next edge.
  - While `pause_r`=1 the prescaler holds its value; it does not reset.
- Decrement:
  - On `tick` with `rest_time`>0, `rest_time` decrements by 1.
  - At 0 it holds at 0; no wrap to 127.
  - `expired` is 1 for exactly the cycle after the edge where `rest_time` goes 1->0; it is 0 otherwise, including on `init_s` and on reset.
- Load vs. tick in the same cycle: the load wins and the tick is discarded.
- BCD:
  - `tens`/`ones` are registered, lagging `rest_time` by exactly one cycle.
  - `tens` = `rest_time`/10, `ones` = `rest_time`%10.
  - Since `rest_time` <= 99, `tens` is always <= 9.
- State summary (implicit FSM on `rest_time`):
  - IDLE (`rest_time`=0): waits for a load.
  - RUN (>0, not paused): decrements on each tick.
  - HOLD (>0, paused): frozen.
- Reset mid-count returns to IDLE immediately. The controller sees `rest_time`=0 on the next cycle.

Decomposition:
- Shared package `traffic_pkg`: the count width constant (7), the FIVE/EIGHT defaults, MAX_VAL, and the load-source priority encoding used by this block and the controller.
- One sub-module, `bin2bcd_reg`: 7-bit binary to 2-digit BCD, registered, with synchronous active-high reset on `rst`.
- Prescaler, clamp, and priority logic stay inline.

Test Plan:
1. CLK_DIV=4, `green_time`=3, pulse `green_s`: `rest_time`=3 the next cycle, then 2, 1, 0 at 4-cycle spacing. `expired` pulses once, the cycle after reaching 0; `tens`/`ones` trail by one cycle (0/3 ... 0/0).
2. `red_time`=25, pulse `red_s`, then `pause_r`=1 for 20 cycles after 2 ticks: `rest_time` holds at 23. After release the next decrement comes after the remaining prescaler count.
3. Simultaneous `red_s`, `green_s`, and `five_time` with `red_time`=10, `green_time`=20: `rest_time`=10. `init_s` together with `save_s`: `rest_time`=0 and no `expired` pulse.
4. Clamping: `yellow_time`=0 loads 1; `green_time`=120 loads 99 (`tens`=9, `ones`=9); `save_s` with `p_rest_time`=0 loads 1; `eight_time` loads 8 regardless of config inputs.
5. Assert `rst` mid-count at `rest_time`=7 while `green_s` is also high: all outputs are 0 after the edge, and the count stays 0 with no strobes.
6. Load on the same cycle as `tick` (`rest_time`=5, `green_s` with `green_time`=9 at prescaler=3): `rest_time`=9, prescaler 0, and the next decrement comes 4 cycles later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants and load-source encoding for the traffic light countdown path.
package traffic_pkg;

   localparam int unsigned CNT_W     = 7;
   localparam int unsigned FIVE_DEF  = 5;
   localparam int unsigned EIGHT_DEF = 8;
   localparam int unsigned MAX_DEF   = 99;

   // Load sources in descending priority order (SRC_NONE = no load this cycle).
   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_INIT,
      SRC_SAVE,
      SRC_RED,
      SRC_YELLOW,
      SRC_GREEN,
      SRC_EIGHT,
      SRC_FIVE
   } load_src_t;

   // Clamp a loaded duration into [1, max_v]; a zero load would skip a phase.
   function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v,
                                                   input logic [CNT_W-1:0] max_v);
      logic [CNT_W-1:0] r;
      if (v == '0)
         r = CNT_W'(1);
      else if (v > max_v)
         r = max_v;
      else
         r = v;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_reg.sv
// Registered 7-bit binary to two-digit BCD conversion for the display.
module bin2bcd_reg
   import traffic_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] bin,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);

   // Split the value into decimal digits, one cycle behind the input.
   always_ff @(posedge clk) begin
      if (rst) begin
         tens <= '0;
         ones <= '0;
      end else begin
         tens <= 4'(bin / CNT_W'(10));
         ones <= 4'(bin % CNT_W'(10));
      end
   end

endmodule

// File: rtl/traffic_countdown_timer.sv
// Seconds countdown for the traffic light controller: strobe-driven reloads,
// prescaled 1 s decrement, pause hold, BCD digits and an expiry pulse.
module traffic_countdown_timer
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 100_000_000,
   parameter int unsigned DIV_W     = 27,
   parameter int unsigned FIVE_VAL  = FIVE_DEF,
   parameter int unsigned EIGHT_VAL = EIGHT_DEF,
   parameter int unsigned MAX_VAL   = MAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause_r,
   input  logic             green_s,
   input  logic             yellow_s,
   input  logic             red_s,
   input  logic             five_time,
   input  logic             eight_time,
   input  logic             save_s,
   input  logic             init_s,
   input  logic [CNT_W-1:0] green_time,
   input  logic [CNT_W-1:0] yellow_time,
   input  logic [CNT_W-1:0] red_time,
   input  logic [CNT_W-1:0] p_rest_time,
   output logic [CNT_W-1:0] rest_time,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic             expired
);

   load_src_t        load_src;
   logic [CNT_W-1:0] raw_val;
   logic [CNT_W-1:0] load_val;
   logic             load_en;
   logic [DIV_W-1:0] presc;
   logic             tick;

   // Pick the highest-priority strobe and its raw load value.
   always_comb begin
      load_src = SRC_NONE;
      raw_val  = '0;
      if (init_s) begin
         load_src = SRC_INIT;
      end else if (save_s) begin
         load_src = SRC_SAVE;
         raw_val  = p_rest_time;
      end else if (red_s) begin
         load_src = SRC_RED;
         raw_val  = red_time;
      end else if (yellow_s) begin
         load_src = SRC_YELLOW;
         raw_val  = yellow_time;
      end else if (green_s) begin
         load_src = SRC_GREEN;
         raw_val  = green_time;
      end else if (eight_time) begin
         load_src = SRC_EIGHT;
         raw_val  = CNT_W'(EIGHT_VAL);
      end else if (five_time) begin
         load_src = SRC_FIVE;
         raw_val  = CNT_W'(FIVE_VAL);
      end
   end

   assign load_en  = (load_src != SRC_NONE);
   assign load_val = (load_src == SRC_INIT) ? '0 : clamp_load(raw_val, CNT_W'(MAX_VAL));
   assign tick     = !pause_r && (presc == DIV_W'(CLK_DIV - 1));

   // Count state: loads win over ticks, pause freezes prescaler and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         rest_time <= '0;
         presc     <= '0;
         expired   <= 1'b0;
      end else if (load_en) begin
         rest_time <= load_val;
         presc     <= '0;
         expired   <= 1'b0;
      end else if (!pause_r) begin
         if (tick)
            presc <= '0;
         else
            presc <= presc + DIV_W'(1);
         if (tick && rest_time != '0)
            rest_time <= rest_time - CNT_W'(1);
         expired <= tick && (rest_time == CNT_W'(1));
      end else begin
         expired <= 1'b0;
      end
   end

   bin2bcd_reg u_bcd (
      .clk  (clk),
      .rst  (rst),
      .bin  (rest_time),
      .tens (tens),
      .ones (ones)
   );

endmodule

// File: tb/tb_traffic_countdown_timer.sv
// Self-checking bench for traffic_countdown_timer with CLK_DIV=4.
module tb_traffic_countdown_timer;

   localparam int CDIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pause_r = 1'b0;
   logic       green_s = 1'b0, yellow_s = 1'b0, red_s = 1'b0;
   logic       five_time = 1'b0, eight_time = 1'b0, save_s = 1'b0, init_s = 1'b0;
   logic [6:0] green_time = '0, yellow_time = '0, red_time = '0, p_rest_time = '0;
   logic [6:0] rest_time;
   logic [3:0] tens, ones;
   logic       expired;

   int checks = 0;
   int errors = 0;

   // Reference model state: seconds left, cycles into current second, outputs.
   int m_rest = 0, m_ph = 0, m_exp = 0, m_tens = 0, m_ones = 0;

   traffic_countdown_timer #(
      .CLK_DIV (CDIV),
      .DIV_W   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pause_r     (pause_r),
      .green_s     (green_s),
      .yellow_s    (yellow_s),
      .red_s       (red_s),
      .five_time   (five_time),
      .eight_time  (eight_time),
      .save_s      (save_s),
      .init_s      (init_s),
      .green_time  (green_time),
      .yellow_time (yellow_time),
      .red_time    (red_time),
      .p_rest_time (p_rest_time),
      .rest_time   (rest_time),
      .tens        (tens),
      .ones        (ones),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      if (v < 1) return 1;
      if (v > 99) return 99;
      return v;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      int nt, no;
      nt = m_rest / 10;
      no = m_rest % 10;
      if (rst) begin
         m_rest = 0; m_ph = 0; m_exp = 0; m_tens = 0; m_ones = 0;
         return;
      end
      m_tens = nt;
      m_ones = no;
      if (init_s || save_s || red_s || yellow_s || green_s || eight_time || five_time) begin
         if (init_s)          m_rest = 0;
         else if (save_s)     m_rest = clampv(int'(p_rest_time));
         else if (red_s)      m_rest = clampv(int'(red_time));
         else if (yellow_s)   m_rest = clampv(int'(yellow_time));
         else if (green_s)    m_rest = clampv(int'(green_time));
         else if (eight_time) m_rest = 8;
         else                 m_rest = 5;
         m_ph  = 0;
         m_exp = 0;
      end else if (pause_r) begin
         m_exp = 0;
      end else if (m_ph == CDIV - 1) begin
         m_ph  = 0;
         m_exp = (m_rest == 1) ? 1 : 0;
         if (m_rest > 0) m_rest--;
      end else begin
         m_ph++;
         m_exp = 0;
      end
   endtask

   // One clock: inputs already driven, edge, model update, compare all outputs.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("rest_time", int'(rest_time), m_rest);
      chk("tens", int'(tens), m_tens);
      chk("ones", int'(ones), m_ones);
      chk("expired", int'(expired), m_exp);
   endtask

   task automatic clear_strobes();
      green_s = 0; yellow_s = 0; red_s = 0; five_time = 0;
      eight_time = 0; save_s = 0; init_s = 0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // strb bits: {init, save, red, yellow, green, eight, five}
   typedef struct {
      logic [6:0] strb;
      logic [6:0] g, y, r, p;
      int         exp_rest;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{7'b0000100,   3,  0,  0,  0,  3};
      vecs[1]  = '{7'b0010101,  20,  0, 10,  0, 10};
      vecs[2]  = '{7'b1100000,   0,  0,  0, 50,  0};
      vecs[3]  = '{7'b0001000,   0,  0,  0,  0,  1};
      vecs[4]  = '{7'b0000100, 120,  0,  0,  0, 99};
      vecs[5]  = '{7'b0100000,   0,  0,  0,  0,  1};
      vecs[6]  = '{7'b0000010,  50, 50, 50, 50,  8};
      vecs[7]  = '{7'b0000001,  50, 50, 50, 50,  5};
      vecs[8]  = '{7'b0110000,   0,  0,  7, 42, 42};
      vecs[9]  = '{7'b0001100,  30, 12,  0,  0, 12};
      vecs[10] = '{7'b0000011,   0,  0,  0,  0,  8};
      vecs[11] = '{7'b0010000,   0,  0, 99,  0, 99};
      vecs[12] = '{7'b0000100, 127,  0,  0,  0, 99};

      // Reset state
      rst = 1;
      cycles(2);
      chk("reset_rest", int'(rest_time), 0);
      rst = 0;
      cycles(3);

      // Table-driven load priority and clamping
      foreach (vecs[k]) begin
         {init_s, save_s, red_s, yellow_s, green_s, eight_time, five_time} = vecs[k].strb;
         green_time = vecs[k].g; yellow_time = vecs[k].y;
         red_time = vecs[k].r;   p_rest_time = vecs[k].p;
         cycle();
         chk($sformatf("vec%0d_rest", k), int'(rest_time), vecs[k].exp_rest);
         chk($sformatf("vec%0d_expired", k), int'(expired), 0);
         clear_strobes();
         cycle();
      end

      // Basic countdown green=3
      green_time = 3; green_s = 1; cycle(); clear_strobes();
      chk("cd_load", int'(rest_time), 3);
      cycles(4); chk("cd_2", int'(rest_time), 2);
      cycles(4); chk("cd_1", int'(rest_time), 1);
      cycles(4); chk("cd_0", int'(rest_time), 0);
      chk("cd_expired", int'(expired), 1);
      chk("cd_ones_lag", int'(ones), 1);
      cycle(); chk("cd_expired_off", int'(expired), 0);
      chk("cd_ones", int'(ones), 0);
      cycles(8); chk("cd_hold0", int'(rest_time), 0);

      // Pause after two ticks
      red_time = 25; red_s = 1; cycle(); clear_strobes();
      cycles(8); chk("pause_23", int'(rest_time), 23);
      cycles(2);
      pause_r = 1; cycles(20); chk("pause_hold", int'(rest_time), 23);
      pause_r = 0; cycle(); chk("pause_rel1", int'(rest_time), 23);
      cycle(); chk("pause_rel2", int'(rest_time), 22);

      // Load while paused is honoured, then held
      pause_r = 1; five_time = 1; cycle(); clear_strobes();
      chk("pause_load", int'(rest_time), 5);
      cycles(10); chk("pause_load_hold", int'(rest_time), 5);
      pause_r = 0;

      // Clamp 120 -> 99 shows as 9/9 one cycle later
      green_time = 120; green_s = 1; cycle(); clear_strobes();
      cycle(); chk("bcd_tens99", int'(tens), 9); chk("bcd_ones99", int'(ones), 9);

      // init with save: zero, no expiry
      init_s = 1; save_s = 1; p_rest_time = 40; cycle(); clear_strobes();
      chk("init_rest", int'(rest_time), 0); chk("init_exp", int'(expired), 0);

      // Reset mid-count at 7 with green_s also high
      green_time = 9; green_s = 1; cycle(); clear_strobes();
      cycles(8); chk("rst_at7", int'(rest_time), 7);
      rst = 1; green_s = 1; cycle(); rst = 0; clear_strobes();
      chk("rst_rest", int'(rest_time), 0); chk("rst_tens", int'(tens), 0);
      chk("rst_ones", int'(ones), 0); chk("rst_exp", int'(expired), 0);
      cycles(10); chk("rst_stay0", int'(rest_time), 0);

      // Load coincident with tick
      green_time = 5; green_s = 1; cycle(); clear_strobes();
      cycles(3);
      green_time = 9; green_s = 1; cycle(); clear_strobes();
      chk("lt_load", int'(rest_time), 9);
      cycles(3); chk("lt_hold", int'(rest_time), 9);
      cycle(); chk("lt_dec", int'(rest_time), 8);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         pause_r    = ($urandom_range(0, 5) == 0) ? ~pause_r : pause_r;
         init_s     = ($urandom_range(0, 89) == 0);
         save_s     = ($urandom_range(0, 59) == 0);
         red_s      = ($urandom_range(0, 39) == 0);
         yellow_s   = ($urandom_range(0, 39) == 0);
         green_s    = ($urandom_range(0, 39) == 0);
         eight_time = ($urandom_range(0, 59) == 0);
         five_time  = ($urandom_range(0, 59) == 0);
         green_time  = 7'($urandom_range(0, 12));
         yellow_time = 7'($urandom_range(0, 127));
         red_time    = 7'($urandom_range(0, 15));
         p_rest_time = 7'($urandom_range(0, 127));
         cycle();
      end
      rst = 0; clear_strobes(); pause_r = 0;
      cycles(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog timeout got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
